// File: rtl/mips_cpu_lsu_pkg.sv
// Shared types and helpers for the MIPS CPU load/store unit.
package mips_cpu_lsu_pkg;

  localparam logic [31:0] DATA_BASE_DEFAULT  = 32'h0000_1000;
  localparam int          DATA_WORDS_DEFAULT = 64;

  // Request opcodes; codes 7 and 11..15 are illegal.
  typedef enum logic [3:0] {
    OP_LB  = 4'd0,
    OP_LBU = 4'd1,
    OP_LH  = 4'd2,
    OP_LHU = 4'd3,
    OP_LW  = 4'd4,
    OP_LWL = 4'd5,
    OP_LWR = 4'd6,
    OP_SB  = 4'd8,
    OP_SH  = 4'd9,
    OP_SW  = 4'd10
  } lsu_op_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STORE,
    ST_RMW_READ,
    ST_RMW_WRITE,
    ST_RESP
  } lsu_state_t;

  function automatic logic is_load(input logic [3:0] op);
    return op <= 4'd6;
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op == 4'd8) || (op == 4'd9) || (op == 4'd10);
  endfunction

endpackage

// File: rtl/mips_cpu_lsu_align.sv
// Big-endian lane steering: load extraction/merge and sub-word store merge.
module mips_cpu_lsu_align
  import mips_cpu_lsu_pkg::*;
(
  input  logic [31:0] word,
  input  lsu_op_t     op,
  input  logic [1:0]  offset,
  input  logic [31:0] rt_old,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);

  // Byte offset 0 lives in bits [31:24], so lane shift is (3-offset)*8.
  function automatic logic [31:0] extract(input logic [31:0] w, input lsu_op_t o,
                                          input logic [1:0] k, input logic [31:0] rt);
    logic [7:0]  b;
    logic [15:0] h;
    logic [4:0]  sh;
    b  = w[{~k, 3'b000} +: 8];
    h  = k[1] ? w[15:0] : w[31:16];
    sh = 5'd0;
    case (o)
      OP_LB:   extract = {{24{b[7]}}, b};
      OP_LBU:  extract = {24'h0, b};
      OP_LH:   extract = {{16{h[15]}}, h};
      OP_LHU:  extract = {16'h0, h};
      OP_LWL: begin
        // Memory bytes k..3 move up to the top lanes; low k lanes keep rt.
        sh      = {k, 3'b000};
        extract = (w << sh) | (rt & ~(32'hFFFF_FFFF << sh));
      end
      OP_LWR: begin
        // Memory bytes 0..k move down to the low lanes; high lanes keep rt.
        sh      = {~k, 3'b000};
        extract = (w >> sh) | (rt & ~(32'hFFFF_FFFF >> sh));
      end
      default: extract = w;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] wd,
                                        input lsu_op_t o, input logic [1:0] k);
    logic [4:0] sh;
    sh = 5'd0;
    case (o)
      OP_SB: begin
        sh    = {~k, 3'b000};
        merge = (w & ~(32'h0000_00FF << sh)) | ({24'h0, wd[7:0]} << sh);
      end
      OP_SH: begin
        sh    = {~k[1], 4'b0000};
        merge = (w & ~(32'h0000_FFFF << sh)) | ({16'h0, wd[15:0]} << sh);
      end
      OP_SW:   merge = wd;
      default: merge = w;
    endcase
  endfunction

  // Pure combinational steering of the current memory word.
  always_comb begin
    load_data  = extract(word, op, offset, rt_old);
    store_word = merge(word, wdata, op, offset);
  end

endmodule

// File: rtl/mips_cpu_load_store_unit.sv
// Load/store unit: accepts one EX/MEM request at a time and drives data memory.
module mips_cpu_load_store_unit
  import mips_cpu_lsu_pkg::*;
#(
  parameter logic [31:0] DATA_BASE  = DATA_BASE_DEFAULT,
  parameter int          DATA_WORDS = DATA_WORDS_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_rt_old,
  output logic        busy,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic [31:0] data_address,
  output logic        data_read,
  output logic        data_write,
  output logic [31:0] data_writedata,
  input  logic [31:0] data_readdata
);

  localparam logic [31:0] DATA_LIMIT = DATA_BASE + 32'(DATA_WORDS * 4);

  lsu_state_t  state_q, state_d;
  lsu_op_t     op_q, op_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rt_old_q, rt_old_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] wr_word_q, wr_word_d;
  logic        err_q, err_d;

  logic [31:0] load_data;
  logic [31:0] store_word;
  logic        req_bad;

  mips_cpu_lsu_align u_align (
    .word       (data_readdata),
    .op         (op_q),
    .offset     (addr_q[1:0]),
    .rt_old     (rt_old_q),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_word (store_word)
  );

  // Request legality: opcode, natural alignment and data-window range.
  always_comb begin
    req_bad = !(is_load(req_op) || is_store(req_op));
    if ((req_op == OP_LH || req_op == OP_LHU || req_op == OP_SH) && req_addr[0])
      req_bad = 1'b1;
    if ((req_op == OP_LW || req_op == OP_SW) && (req_addr[1:0] != 2'b00))
      req_bad = 1'b1;
    if ((req_addr < DATA_BASE) || (req_addr >= DATA_LIMIT))
      req_bad = 1'b1;
  end

  // Next-state and datapath capture.
  // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rt_old_d  = rt_old_q;
    rdata_d   = rdata_q;
    wr_word_d = wr_word_q;
    err_d     = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          op_d     = lsu_op_t'(req_op);
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          rt_old_d = req_rt_old;
          rdata_d  = 32'h0;
          err_d    = req_bad;
          if (req_bad)                state_d = ST_RESP;
          else if (is_load(req_op))   state_d = ST_LOAD;
          else if (req_op == OP_SW)   state_d = ST_STORE;
          else                        state_d = ST_RMW_READ;
        end
      end
      ST_LOAD: begin
        rdata_d = load_data;
        state_d = ST_RESP;
      end
      ST_STORE:     state_d = ST_RESP;
      ST_RMW_READ: begin
        wr_word_d = store_word;
        state_d   = ST_RMW_WRITE;
      end
      ST_RMW_WRITE: state_d = ST_RESP;
      ST_RESP:      state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // State and capture registers with synchronous reset.
  // NOTE: flops use non-blocking assignment so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_LB;
      addr_q    <= 32'h0;
      wdata_q   <= 32'h0;
      rt_old_q  <= 32'h0;
      rdata_q   <= 32'h0;
      wr_word_q <= 32'h0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rt_old_q  <= rt_old_d;
      rdata_q   <= rdata_d;
      wr_word_q <= wr_word_d;
      err_q     <= err_d;
    end
  end

  // Outputs decode from the state register only; strobes are mutually exclusive.
  always_comb begin
    busy           = (state_q != ST_IDLE);
    data_read      = (state_q == ST_LOAD)  || (state_q == ST_RMW_READ);
    data_write     = (state_q == ST_STORE) || (state_q == ST_RMW_WRITE);
    data_address   = {addr_q[31:2], 2'b00};
    data_writedata = 32'h0;
    if (state_q == ST_STORE)     data_writedata = wdata_q;
    if (state_q == ST_RMW_WRITE) data_writedata = wr_word_q;
    resp_valid     = (state_q == ST_RESP);
    resp_error     = resp_valid && err_q;
    resp_rdata     = resp_valid ? rdata_q : 32'h0;
  end

endmodule

// File: tb/tb_mips_cpu_load_store_unit.sv
// Directed bench for the load/store unit with a small word-memory model.
module tb_mips_cpu_load_store_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [3:0]  req_op;
  logic [31:0] req_addr, req_wdata, req_rt_old;
  logic        busy, resp_valid, resp_error, data_read, data_write;
  logic [31:0] resp_rdata, data_address, data_writedata, data_readdata;

  logic [31:0] mem [0:63];
  logic        preload;
  int          both_cnt = 0;
  int          checks = 0;
  int          errors = 0;

  mips_cpu_load_store_unit dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_op         (req_op),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_rt_old     (req_rt_old),
    .busy           (busy),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_error     (resp_error),
    .data_address   (data_address),
    .data_read      (data_read),
    .data_write     (data_write),
    .data_writedata (data_writedata),
    .data_readdata  (data_readdata)
  );

  always #5 clk = ~clk;

  // Memory window 0x1000..0x10FF: word index is address bits [7:2].
  assign data_readdata = data_read ? mem[data_address[7:2]] : 32'h0;

  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      mem[1] <= 32'h8899_AABB;
    end else if (data_write) begin
      mem[data_address[7:2]] <= data_writedata;
    end
  end

  always @(negedge clk) if (data_read && data_write) both_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_preload();
    preload = 1'b1;
    @(posedge clk); #1;
    preload = 1'b0;
  endtask

  // Issue one request, then watch cycles after the accept edge until resp_valid.
  task automatic run_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] rt, input bit hold,
                        output int lat, output logic [31:0] rdata, output logic err,
                        output int nrd, output int nwr, output logic [31:0] wd_seen);
    lat = -1; rdata = 32'h0; err = 1'b0; nrd = 0; nwr = 0; wd_seen = 32'h0;
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd; req_rt_old = rt;
    @(posedge clk); #1;
    if (!hold) req_valid = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (data_read) nrd++;
      if (data_write) begin nwr++; wd_seen = data_writedata; end
      if (resp_valid) begin
        lat = c; rdata = resp_rdata; err = resp_error;
        break;
      end
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  int          lat, nrd, nwr, extra;
  logic [31:0] rd, wds;
  logic        er;

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_op = 4'd0; req_addr = 32'h0;
    req_wdata = 32'h0; req_rt_old = 32'h0; preload = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_error", 32'(resp_error), 32'd0);
    check("rst_strobes", {30'd0, data_read, data_write}, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_data_address", data_address, 32'h0);
    check("rst_data_writedata", data_writedata, 32'h0);
    reset = 1'b0;
    do_preload();

    run_op(4'd0, 32'h1005, 32'h0, 32'h0, 0, lat, rd, er, nrd, nwr, wds);
    check("lb_data", rd, 32'hFFFF_FF99);
    check("lb_lat", 32'(lat), 32'd2);
    check("lb_err", 32'(er), 32'd0);
    check("lb_writes", 32'(nwr), 32'd0);

    run_op(4'd1, 32'h1005, 32'h0, 32'h0, 0, lat, rd, er, nrd, nwr, wds);
    check("lbu_data", rd, 32'h0000_0099);

    run_op(4'd2, 32'h1006, 32'h0, 32'h0, 0, lat, rd, er, nrd, nwr, wds);
    check("lh_data", rd, 32'hFFFF_AABB);
    run_op(4'd3, 32'h1004, 32'h0, 32'h0, 0, lat, rd, er, nrd, nwr, wds);
    check("lhu_data", rd, 32'h0000_8899);

    run_op(4'd8, 32'h1006, 32'h0000_00CC, 32'h0, 0, lat, rd, er, nrd, nwr, wds);
    check("sb_lat", 32'(lat), 32'd3);
    check("sb_reads", 32'(nrd), 32'd1);
    check("sb_writes", 32'(nwr), 32'd1);
    check("sb_wdata", wds, 32'h8899_CCBB);
    check("sb_rdata", rd, 32'h0);
    run_op(4'd4, 32'h1004, 32'h0, 32'h0, 0, lat, rd, er, nrd, nwr, wds);
    check("sb_lw_back", rd, 32'h8899_CCBB);
    check("lw_lat", 32'(lat), 32'd2);

    do_preload();
    run_op(4'd2, 32'h1003, 32'h0, 32'h0, 0, lat, rd, er, nrd, nwr, wds);
    check("lh_mis_err", 32'(er), 32'd1);
    check("lh_mis_rdata", rd, 32'h0);
    check("lh_mis_lat", 32'(lat), 32'd1);
    check("lh_mis_strobes", 32'(nrd + nwr), 32'd0);

    run_op(4'd5, 32'h1005, 32'h0, 32'h1122_3344, 0, lat, rd, er, nrd, nwr, wds);
    check("lwl_k1", rd, 32'h99AA_BB44);
    run_op(4'd6, 32'h1005, 32'h0, 32'h1122_3344, 0, lat, rd, er, nrd, nwr, wds);
    check("lwr_k1", rd, 32'h1122_8899);
    run_op(4'd5, 32'h1004, 32'h0, 32'h1122_3344, 0, lat, rd, er, nrd, nwr, wds);
    check("lwl_k0", rd, 32'h8899_AABB);
    run_op(4'd6, 32'h1007, 32'h0, 32'h1122_3344, 0, lat, rd, er, nrd, nwr, wds);
    check("lwr_k3", rd, 32'h8899_AABB);

    run_op(4'd9, 32'h1004, 32'h0000_1234, 32'h0, 0, lat, rd, er, nrd, nwr, wds);
    check("sh_wdata", wds, 32'h1234_AABB);
    check("sh_lat", 32'(lat), 32'd3);

    run_op(4'd10, 32'h1008, 32'hDEAD_BEEF, 32'h0, 1, lat, rd, er, nrd, nwr, wds);
    check("sw_lat", 32'(lat), 32'd2);
    check("sw_writes", 32'(nwr), 32'd1);
    check("sw_wdata", wds, 32'hDEAD_BEEF);
    extra = 0;
    for (int c = 0; c < 3; c++) begin
      if (busy || resp_valid || data_write) extra++;
      @(posedge clk); #1;
    end
    check("sw_single_accept", 32'(extra), 32'd0);
    run_op(4'd4, 32'h1008, 32'h0, 32'h0, 0, lat, rd, er, nrd, nwr, wds);
    check("sw_lw_back", rd, 32'hDEAD_BEEF);

    run_op(4'd4, 32'h0FFC, 32'h0, 32'h0, 0, lat, rd, er, nrd, nwr, wds);
    check("below_base_err", 32'(er), 32'd1);
    check("below_base_strobes", 32'(nrd + nwr), 32'd0);
    run_op(4'd4, 32'h1100, 32'h0, 32'h0, 0, lat, rd, er, nrd, nwr, wds);
    check("past_top_err", 32'(er), 32'd1);
    run_op(4'd4, 32'h10FC, 32'h0, 32'h0, 0, lat, rd, er, nrd, nwr, wds);
    check("top_word_err", 32'(er), 32'd0);
    check("top_word_lat", 32'(lat), 32'd2);
    run_op(4'd7, 32'h1004, 32'h0, 32'h0, 0, lat, rd, er, nrd, nwr, wds);
    check("op7_err", 32'(er), 32'd1);
    run_op(4'd11, 32'h1004, 32'h0, 32'h0, 0, lat, rd, er, nrd, nwr, wds);
    check("op11_err", 32'(er), 32'd1);
    run_op(4'd10, 32'h1002, 32'h5555_5555, 32'h0, 0, lat, rd, er, nrd, nwr, wds);
    check("sw_mis_err", 32'(er), 32'd1);
    check("sw_mis_writes", 32'(nwr), 32'd0);

    do_preload();
    req_valid = 1'b1; req_op = 4'd9; req_addr = 32'h1004; req_wdata = 32'h0000_7777;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rmw_read_strobe", 32'(data_read), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_resp", 32'(resp_valid), 32'd0);
    extra = 0;
    for (int c = 0; c < 3; c++) begin
      if (resp_valid || data_write) extra++;
      @(posedge clk); #1;
    end
    check("rst_mid_quiet", 32'(extra), 32'd0);
    check("rst_mid_mem", mem[1], 32'h8899_AABB);
    run_op(4'd4, 32'h1004, 32'h0, 32'h0, 0, lat, rd, er, nrd, nwr, wds);
    check("rst_mid_lw", rd, 32'h8899_AABB);

    check("strobes_exclusive", 32'(both_cnt), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
